adc_serial_reg_receiver: RTL and testbench

//  Synthesizable responder for the ADC extended-control 3-wire write interface
//  (Select/Sclk/Sdata). Oversamples the bus on Clock, deframes 32-bit write

---
 rtl/adc_serial_reg_receiver.sv | 131 +++++++++++++
 tb/tb_adc_serial_reg_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_reg_receiver.sv
// 3-wire (Select/Sclk/Sdata) write responder: oversampled on Clock, deframes
// 32-bit frames, checks the header and commits data to a 16x16 register file.
module adc_serial_reg_receiver #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] HEADER      = 12'h001,
    parameter logic [3:0]  DES_ADDR    = 4'hD,
    parameter int          DES_BIT     = 7,
    parameter logic [15:0] REG_RESET   = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InSclk,
    input  logic        InSdata,
    input  logic        InSelect,
    input  logic [3:0]  RdAddr,
    output logic [15:0] RdData,
    output logic        WrStrobe,
    output logic [3:0]  WrAddr,
    output logic [15:0] WrData,
    output logic        DesEnable,
    output logic        FrameError,
    output logic        HeaderError,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [5:0] COUNT_SAT = 6'd33;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, sel_sync_q;
    logic                   sclk_prev_q, sel_prev_q;
    logic                   sclk_s, sdata_s, sel_s;
    logic                   sclk_rise, sel_fall, sel_rise;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] shreg_q, shreg_d;
    logic [15:0] regs_q [16];

    // Synchronizers idle at Sclk=0, Sdata=0, Select=1 so reset never fakes an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            sel_sync_q   <= '1;
            sclk_prev_q  <= 1'b0;
            sel_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], InSclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], InSdata};
            sel_sync_q   <= {sel_sync_q[SYNC_STAGES-2:0], InSelect};
            sclk_prev_q  <= sclk_s;
            sel_prev_q   <= sel_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
    assign sel_s     = sel_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sel_fall  = ~sel_s & sel_prev_q;
    assign sel_rise  = sel_s & ~sel_prev_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        WrStrobe    = 1'b0;
        FrameError  = 1'b0;
        HeaderError = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_fall) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT: begin
                // A coincident Sclk rise is shifted in before CHECK looks at the count.
                if (sclk_rise) begin
                    shreg_d = {shreg_q[30:0], sdata_s};
                    count_d = (count_q == COUNT_SAT) ? COUNT_SAT : count_q + 6'd1;
                end
                if (sel_rise) state_d = CHECK;
            end
            CHECK: begin
                if (count_q != 6'd32)               FrameError  = 1'b1;
                else if (shreg_q[31:20] != HEADER)  HeaderError = 1'b1;
                else                                WrStrobe    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register file is reset explicitly because REG_RESET is a visible contract.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= REG_RESET;
            WrAddr <= '0;
            WrData <= '0;
        end else if (WrStrobe) begin
            regs_q[shreg_q[19:16]] <= shreg_q[15:0];
            WrAddr                 <= shreg_q[19:16];
            WrData                 <= shreg_q[15:0];
        end
    end

    assign RdData    = regs_q[RdAddr];
    assign DesEnable = regs_q[DES_ADDR][DES_BIT];
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adc_serial_reg_receiver.sv
// Randomized frame bench for adc_serial_reg_receiver with a frame-level
// reference model (bit list in, outcome and register array out).
module tb_adc_serial_reg_receiver;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InSclk = 1'b0;
    logic        InSdata = 1'b0;
    logic        InSelect = 1'b1;
    logic [3:0]  RdAddr = '0;
    logic [15:0] RdData;
    logic        WrStrobe;
    logic [3:0]  WrAddr;
    logic [15:0] WrData;
    logic        DesEnable;
    logic        FrameError;
    logic        HeaderError;
    logic        Busy;

    adc_serial_reg_receiver dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InSclk      (InSclk),
        .InSdata     (InSdata),
        .InSelect    (InSelect),
        .RdAddr      (RdAddr),
        .RdData      (RdData),
        .WrStrobe    (WrStrobe),
        .WrAddr      (WrAddr),
        .WrData      (WrData),
        .DesEnable   (DesEnable),
        .FrameError  (FrameError),
        .HeaderError (HeaderError),
        .Busy        (Busy)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_wr = 0, n_fe = 0, n_he = 0;

    logic [15:0] model_mem [16];
    logic [3:0]  model_wraddr;
    logic [15:0] model_wrdata;

    always @(negedge Clock) begin
        if (!Reset) begin
            if (WrStrobe)    n_wr++;
            if (FrameError)  n_fe++;
            if (HeaderError) n_he++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        InSelect = 1'b1;
        InSclk   = 1'b0;
        InSdata  = 1'b0;
        clk(4);
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        model_wraddr = '0;
        model_wrdata = '0;
        clk(2);
    endtask

    // Drives the low nbits of word MSB first; half = Sclk half-period in Clocks.
    task automatic send(input logic [63:0] word, input int nbits, input int half, input bit coincide);
        InSelect = 1'b0;
        clk(2 * half);
        for (int i = nbits - 1; i >= 0; i--) begin
            InSdata = word[i];
            clk(half);
            InSclk = 1'b1;
            if (coincide && i == 0) InSelect = 1'b1;
            clk(half);
            InSclk = 1'b0;
            if (i == nbits / 2) check("busy_mid_frame", Busy, 1'b1);
        end
        if (!coincide) begin
            clk(half);
            InSelect = 1'b1;
        end
        clk(10);
    endtask

    task automatic do_frame(input logic [63:0] word, input int nbits, input int half, input bit coincide);
        int wr0, fe0, he0;
        int exp_wr, exp_fe, exp_he;
        logic [3:0] a;
        wr0 = n_wr; fe0 = n_fe; he0 = n_he;
        exp_wr = 0; exp_fe = 0; exp_he = 0;
        a = word[19:16];
        send(word, nbits, half, coincide);
        if (nbits != 32)                exp_fe = 1;
        else if (word[31:20] != 12'h001) exp_he = 1;
        else begin
            exp_wr = 1;
            model_mem[a] = word[15:0];
            model_wraddr = a;
            model_wrdata = word[15:0];
        end
        check("wr_strobe_count", n_wr - wr0, exp_wr);
        check("frame_err_count", n_fe - fe0, exp_fe);
        check("header_err_count", n_he - he0, exp_he);
        check("wr_addr", WrAddr, model_wraddr);
        check("wr_data", WrData, model_wrdata);
        check("des_enable", DesEnable, model_mem[13][7]);
        check("busy_idle", Busy, 1'b0);
        RdAddr = a;
        clk(1);
        check("rd_data", RdData, model_mem[a]);
    endtask

    initial begin
        logic [63:0] w;
        int kind, half, nb;

        do_reset();
        check("reset_busy", Busy, 1'b0);
        check("reset_wr_addr", WrAddr, 4'h0);
        check("reset_wr_data", WrData, 16'h0000);
        check("reset_des", DesEnable, 1'b0);
        check("reset_rd_data", RdData, 16'h0000);

        // Directed scenarios
        do_frame(64'h001D_0080, 32, 4, 1'b0);
        check("des_after_write", DesEnable, 1'b1);
        do_frame(64'h0023_1234, 32, 4, 1'b0);
        do_frame(64'h001D_0080 >> 1, 31, 4, 1'b0);
        do_frame(64'h1_001D_0080, 33, 4, 1'b0);
        do_frame(64'hAB_001D_0080, 40, 4, 1'b0);

        // Abort a valid frame mid-way with reset
        InSelect = 1'b0;
        clk(8);
        w = 64'h0015_5555;
        for (int i = 31; i >= 16; i--) begin
            InSdata = w[i];
            clk(2); InSclk = 1'b1; clk(2); InSclk = 1'b0;
        end
        begin
            int wr0, fe0, he0;
            wr0 = n_wr; fe0 = n_fe; he0 = n_he;
            do_reset();
            clk(6);
            check("abort_no_write", n_wr - wr0, 0);
            check("abort_no_ferr", n_fe - fe0, 0);
            check("abort_no_herr", n_he - he0, 0);
        end
        do_frame(64'h001D_0000, 32, 4, 1'b0);

        // Back-to-back writes to all registers
        for (int a = 0; a < 16; a++)
            do_frame({44'h00000000001, a[3:0], a[15:0] * 16'h1111}, 32, 2, 1'b0);

        // Final Sclk rise coincident with Select rise
        do_frame(64'h0017_BEEF, 32, 3, 1'b1);

        // Randomized mix of good, bad-header and bad-length frames
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 6);
            half = $urandom_range(2, 5);
            w = {$urandom, $urandom};
            nb = 32;
            if (kind <= 2) w[31:20] = 12'h001;
            else if (kind == 3) begin
                w[31:20] = 12'h001 ^ 12'($urandom_range(1, 4095));
            end else if (kind == 4) nb = 31;
            else if (kind == 5) nb = 33;
            else nb = $urandom_range(34, 40);
            do_frame(w, nb, half, ($urandom_range(0, 3) == 0) && nb == 32);
        end

        for (int a = 0; a < 16; a++) begin
            RdAddr = a[3:0];
            clk(1);
            check("readback_sweep", RdData, model_mem[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
